tuart_tx: RTL

UART transmitter for logIP: serializes 8N1 frames onto the host serial line, LSB first. The SUMP response path (sample words, ID and metadata replies) hands it a word of 1 to 4 bytes and a strobe. It emits the bytes least-significant byte first, back to back, then signals completion. Bit timing is set at runtime by a cycles-per-bit divider. This matches the receiver so both ends share one baud configuration.

---
 rtl/tuart_pkg.sv | 18 +
 rtl/tuart_baud_cnt.sv | 37 +++
 rtl/tuart_tx.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tuart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// transmitter state encoding, frame shape constants and the default divider width.
package tuart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;

  localparam int   DEFAULT_CPB_W  = 16;

endpackage

// File: rtl/tuart_baud_cnt.sv
// Loadable baud down-counter. It counts from the loaded value down to zero.
// While enabled, it raises o_tick during the terminal-count cycle and then
// reloads. The receiver reuses this block for its own bit timing.
module tuart_baud_cnt
  import tuart_pkg::*;
#(
  parameter int W = DEFAULT_CPB_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic [W-1:0] i_reload,
  input  logic         i_enable,
  output logic         o_tick
);

  logic [W-1:0] r_count;

  // Explicit load wins; otherwise count down and wrap to the reload value at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_enable) begin
      if (r_count == '0) begin
        r_count <= i_reload;
      end else begin
        r_count <= r_count - W'(1);
      end
    end
  end

  assign o_tick = i_enable && (r_count == '0);

endmodule

// File: rtl/tuart_tx.sv
// UART transmitter. It sends 8N1 frames LSB first and carries 1..WORD_BYTES
// bytes per transfer. Byte 0 goes first, and the bytes are sent back to back.
// Bit time is latched at accept. All outputs come straight from registers.
module tuart_tx
  import tuart_pkg::*;
#(
  parameter  int CPB_W      = DEFAULT_CPB_W,
  parameter  int WORD_BYTES = 4,
  localparam int BI_W       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1,
  localparam int DATA_W     = 8 * WORD_BYTES
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic [CPB_W-1:0]  cycles_per_bit_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [BI_W-1:0]   bytes_i,
  input  logic              stb_i,
  output logic              rdy_o,
  output logic              done_o,
  output logic              tx_o
);

  tx_state_t r_state;
  tx_state_t w_nextState;

  logic [DATA_W-1:0] r_data;
  logic [BI_W-1:0]   r_bytes;
  logic [BI_W-1:0]   r_byteIdx;
  logic [CPB_W-1:0]  r_reload;
  logic [2:0]        r_bitIdx;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_rdy;
  logic              r_done;

  logic              w_tick;
  logic              w_accept;
  logic              w_firstBit;
  logic              w_shiftBit;
  logic              w_loadNext;
  logic              w_txNext;
  logic              w_rdyNext;
  logic              w_doneNext;
  logic [CPB_W-1:0]  w_loadVal;
  logic [BI_W-1:0]   w_nextByteIdx;
  logic [7:0]        w_nextByte;

  // A divider of zero behaves like one, so the counter reload value is N-1 with a floor of 0
  assign w_loadVal     = (cycles_per_bit_i == '0) ? '0 : cycles_per_bit_i - CPB_W'(1);
  assign w_nextByteIdx = r_byteIdx + BI_W'(1);
  assign w_nextByte    = r_data[{w_nextByteIdx, 3'b000} +: 8];

  tuart_baud_cnt #(
    .W(CPB_W)
  ) u_baud (
    .i_clk     (clk_i),
    .i_rst_n   (rst_in),
    .i_load    (w_accept),
    .i_loadVal (w_loadVal),
    .i_reload  (r_reload),
    .i_enable  (r_state != TX_IDLE),
    .o_tick    (w_tick)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= TX_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state, datapath strobes, and the next value of every registered output
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_firstBit  = 1'b0;
    w_shiftBit  = 1'b0;
    w_loadNext  = 1'b0;
    w_txNext    = r_tx;
    w_rdyNext   = r_rdy;
    w_doneNext  = 1'b0;
    case (r_state)
      TX_IDLE: begin
        w_txNext  = UART_STOP_BIT;
        w_rdyNext = 1'b1;
        if (stb_i && r_rdy) begin
          w_accept    = 1'b1;
          w_nextState = TX_START;
          w_txNext    = UART_START_BIT;
          w_rdyNext   = 1'b0;
        end
      end
      TX_START: begin
        if (w_tick) begin
          w_firstBit  = 1'b1;
          w_nextState = TX_DATA;
          w_txNext    = r_shift[0];
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_bitIdx == 3'(UART_DATA_BITS - 1)) begin
            w_nextState = TX_STOP;
            w_txNext    = UART_STOP_BIT;
          end else begin
            w_shiftBit = 1'b1;
            w_txNext   = r_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_byteIdx == r_bytes) begin
            w_nextState = TX_IDLE;
            w_txNext    = UART_STOP_BIT;
            w_rdyNext   = 1'b1;
            w_doneNext  = 1'b1;
          end else begin
            w_loadNext  = 1'b1;
            w_nextState = TX_START;
            w_txNext    = UART_START_BIT;
          end
        end
      end
      default: begin
        w_nextState = TX_IDLE;
        w_txNext    = UART_STOP_BIT;
        w_rdyNext   = 1'b1;
      end
    endcase
  end

  // Latch the transfer on accept, then step bits and bytes at bit boundaries
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_data    <= '0;
      r_bytes   <= '0;
      r_byteIdx <= '0;
      r_reload  <= '0;
      r_bitIdx  <= '0;
      r_shift   <= '0;
    end else begin
      if (w_accept) begin
        r_data    <= data_i;
        r_bytes   <= bytes_i;
        r_reload  <= w_loadVal;
        r_byteIdx <= '0;
        r_bitIdx  <= '0;
        r_shift   <= data_i[7:0];
      end
      if (w_firstBit) begin
        r_bitIdx <= '0;
      end
      if (w_shiftBit) begin
        r_shift  <= {1'b0, r_shift[7:1]};
        r_bitIdx <= r_bitIdx + 3'd1;
      end
      if (w_loadNext) begin
        r_byteIdx <= w_nextByteIdx;
        r_shift   <= w_nextByte;
      end
    end
  end

  // Output registers, so there is no combinational path from any input to an output
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_tx   <= UART_STOP_BIT;
      r_rdy  <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_tx   <= w_txNext;
      r_rdy  <= w_rdyNext;
      r_done <= w_doneNext;
    end
  end

  assign tx_o   = r_tx;
  assign rdy_o  = r_rdy;
  assign done_o = r_done;

endmodule
